// File: rtl/freq_div_pkg.sv
// Shared types and constants for the ADPLL divide-ratio controller.
package freq_div_pkg;

   localparam int RATIO_W    = 3;
   localparam int FRAC_W_DEF = 4;

   localparam logic [RATIO_W-1:0] RATIO_MAX = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      SETTLE
   } state_t;

   typedef struct packed {
      logic [RATIO_W-1:0]    n;
      logic [FRAC_W_DEF-1:0] frac;
   } ratio_t;

   // A zero ratio would stall the divider; every other 3-bit value is usable.
   function automatic logic ratio_legal(input logic [RATIO_W-1:0] n);
      return n != '0;
   endfunction

endpackage

// File: rtl/freq_div_dither.sv
// Fractional N/N+1 dither: phase accumulator plus carry, saturating at ratio 7.
// Only instantiated when FREQ_DIV_CTRL_DITHER_EN is defined.
module freq_div_dither
   import freq_div_pkg::*;
#(
   parameter int FRAC_W = FRAC_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_upd,
   input  logic               i_restart,
   input  logic [RATIO_W-1:0] i_int,
   input  logic [FRAC_W-1:0]  i_frac,
   output logic [RATIO_W-1:0] o_m_next
);

   logic [FRAC_W-1:0] r_acc;
   logic [FRAC_W-1:0] w_base;
   logic [FRAC_W:0]   w_sum;
   logic              w_carry;

   // A fresh commit restarts the phase from zero so the first period is plain N.
   assign w_base   = i_restart ? '0 : r_acc;
   assign w_sum    = {1'b0, w_base} + {1'b0, i_frac};
   assign w_carry  = w_sum[FRAC_W] && (i_int != RATIO_MAX);
   assign o_m_next = i_int + RATIO_W'(w_carry);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc <= '0;
      end else if (i_upd) begin
         r_acc <= w_sum[FRAC_W-1:0];
      end
   end

endmodule

// File: rtl/freq_div_ctrl.sv
// Divide-ratio controller: valid/ready request intake, period-aligned commit, lock timer.
// Define FREQ_DIV_CTRL_DITHER_EN to build the fractional N/N+1 dither path.
module freq_div_ctrl
   import freq_div_pkg::*;
#(
   parameter int DEFAULT_M      = 4,
   parameter int FRAC_W         = FRAC_W_DEF,
   parameter int SETTLE_PERIODS = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic [RATIO_W-1:0] i_req_int,
   input  logic [FRAC_W-1:0]  i_req_frac,
   output logic [RATIO_W-1:0] o_m_out,
   output logic               o_period_start,
   output logic               o_locked,
   output logic               o_req_err
);

   localparam logic [RATIO_W-1:0] M_RST     = RATIO_W'(DEFAULT_M);
   localparam logic [7:0]         SETTLE_LD = 8'(SETTLE_PERIODS);

   state_t             r_state;
   state_t             w_state_next;
   logic [RATIO_W-1:0] r_cnt;
   logic [RATIO_W-1:0] r_m_out;
   logic [RATIO_W-1:0] w_m_next;
   ratio_t             r_shadow;
   ratio_t             r_active;
   logic [7:0]         r_settle;
   logic               r_locked;
   logic               r_err;
   logic               w_ready;
   logic               w_period_start;
   logic               w_upd;
   logic               w_accept;
   logic               w_legal;
   logic               w_commit;
   logic               w_settle_done;

   // The mirror counter tracks the divider; the update edge is the last edge of a period.
   assign w_period_start = (r_cnt == '0);
   assign w_upd          = (r_cnt == RATIO_W'(1)) ||
                           (w_period_start && (r_m_out == RATIO_W'(1)));
   assign w_accept       = i_req_valid && w_ready;
   assign w_legal        = ratio_legal(i_req_int);
   assign w_commit       = (r_state == PENDING) && w_upd;
   // Lock at the edge closing the last counted period (the counter may hit zero on that same edge).
   assign w_settle_done  = (r_state == SETTLE) && w_upd &&
                           ((r_settle == 8'd0) || ((r_settle == 8'd1) && w_period_start));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept && w_legal) w_state_next = PENDING;
         PENDING: if (w_upd)               w_state_next = SETTLE;
         SETTLE:  if (w_settle_done)       w_state_next = IDLE;
         default:                          w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         IDLE:    w_ready = 1'b1;
         default: w_ready = 1'b0;
      endcase
   end

`ifdef FREQ_DIV_CTRL_DITHER_EN
   freq_div_dither #(
      .FRAC_W (FRAC_W)
   ) u_dither (
      .clk       (clk),
      .reset     (reset),
      .i_upd     (w_upd),
      .i_restart (w_commit),
      .i_int     (w_commit ? r_shadow.n    : r_active.n),
      .i_frac    (w_commit ? r_shadow.frac : r_active.frac),
      .o_m_next  (w_m_next)
   );
`else
   logic w_unused_frac;
   assign w_unused_frac = ^r_active.frac;
   assign w_m_next      = w_commit ? r_shadow.n : r_active.n;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_m_out  <= M_RST;
         r_shadow <= '{n: M_RST, frac: '0};
         r_active <= '{n: M_RST, frac: '0};
         r_settle <= '0;
         r_locked <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_cnt <= w_period_start ? (r_m_out - RATIO_W'(1)) : (r_cnt - RATIO_W'(1));
         r_err <= w_accept && !w_legal;
         if (w_accept && w_legal) begin
            r_shadow <= '{n: i_req_int, frac: i_req_frac};
            r_locked <= 1'b0;
         end
         if (w_upd) begin
            r_m_out <= w_m_next;
         end
         if (w_commit) begin
            r_active <= r_shadow;
            r_settle <= SETTLE_LD;
         end else if ((r_state == SETTLE) && w_period_start && (r_settle != 8'd0)) begin
            r_settle <= r_settle - 8'd1;
         end
         if (w_settle_done) begin
            r_locked <= 1'b1;
         end
      end
   end

   assign o_req_ready    = w_ready;
   assign o_m_out        = r_m_out;
   assign o_period_start = w_period_start;
   assign o_locked       = r_locked;
   assign o_req_err      = r_err;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Self-checking bench for freq_div_ctrl; expected per-period ratios go through a queue.
module tb_freq_div_ctrl;

`ifdef FREQ_DIV_CTRL_DITHER_EN
   localparam bit DITH = 1'b1;
`else
   localparam bit DITH = 1'b0;
`endif
   localparam int FW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic [2:0]    req_int = '0;
   logic [FW-1:0] req_frac = '0;
   logic          req_ready;
   logic [2:0]    m_out;
   logic          period_start;
   logic          locked;
   logic          req_err;

   int total = 0;
   int bad   = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   freq_div_ctrl #(
      .DEFAULT_M      (4),
      .FRAC_W         (FW),
      .SETTLE_PERIODS (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_int      (req_int),
      .i_req_frac     (req_frac),
      .o_m_out        (m_out),
      .o_period_start (period_start),
      .o_locked       (locked),
      .o_req_err      (req_err)
   );

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      int exp_m;
      reset = 1'b1;
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      total++;
      if (m_out !== 3'd4 || req_ready !== 1'b1 || locked !== 1'b0 || req_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: m=%0d ready=%0b locked=%0b err=%0b want 4 1 0 0",
                  m_out, req_ready, locked, req_err);
      end
      for (int i = 0; i < 5; i++) exp_q.push_back(4);
      for (int k = 0; k <= 16; k++) begin
         total++;
         if (period_start !== (k % 4 == 0)) begin
            bad++;
            $display("FAIL reset_cadence: cyc=%0d period_start=%0b want %0b", k, period_start, (k % 4 == 0));
         end
         if (period_start === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL reset_sb: extra period_start at cyc=%0d want none", k);
            end else begin
               exp_m = exp_q.pop_front();
               if (m_out !== 3'(exp_m)) begin
                  bad++;
                  $display("FAIL reset_m: cyc=%0d m=%0d want %0d", k, m_out, exp_m);
               end
            end
         end
         if (k < 16) @(negedge clk);
      end
      $display("test_reset: checked 17 cycles after reset release");
   endtask

   task automatic test_n3();
      int exp_m;
      for (int i = 0; i < 8 && period_start !== 1'b1; i++) @(negedge clk);
      total++;
      if (period_start !== 1'b1) begin
         bad++;
         $display("FAIL n3_align: period_start=%0b want 1", period_start);
      end
      repeat (2) @(negedge clk);
      req_valid = 1'b1; req_int = 3'd3; req_frac = '0;
      @(negedge clk);
      req_valid = 1'b0;
      total++;
      if (req_ready !== 1'b0 || m_out !== 3'd4) begin
         bad++;
         $display("FAIL n3_pending: ready=%0b m=%0d want 0 4", req_ready, m_out);
      end
      @(negedge clk);
      for (int i = 0; i < 11; i++) exp_q.push_back(3);
      for (int t = 0; t <= 30; t++) begin
         total++;
         if (period_start !== (t % 3 == 0)) begin
            bad++;
            $display("FAIL n3_cadence: t=%0d period_start=%0b want %0b", t, period_start, (t % 3 == 0));
         end
         total++;
         if (req_ready !== (t >= 24) || locked !== (t >= 24)) begin
            bad++;
            $display("FAIL n3_lock: t=%0d ready=%0b locked=%0b want %0b", t, req_ready, locked, (t >= 24));
         end
         if (period_start === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL n3_sb: extra period_start at t=%0d want none", t);
            end else begin
               exp_m = exp_q.pop_front();
               if (m_out !== 3'(exp_m)) begin
                  bad++;
                  $display("FAIL n3_m: t=%0d m=%0d want %0d", t, m_out, exp_m);
               end
            end
         end
         if (t < 30) @(negedge clk);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL n3_sb_left: remaining=%0d want 0", exp_q.size());
         exp_q.delete();
      end
      $display("test_n3: request N=3 committed and locked");
   endtask

   task automatic test_frac();
      int exp_m = 0;
      int t = 0;
      int last_ps = 0;
      int last_m = 0;
      int n_ps = 0;
      int lock_t;
      lock_t = DITH ? 20 : 16;
      for (int i = 0; i < 8 && period_start !== 1'b1; i++) @(negedge clk);
      total++;
      if (req_ready !== 1'b1 || period_start !== 1'b1) begin
         bad++;
         $display("FAIL frac_align: ready=%0b period_start=%0b want 1 1", req_ready, period_start);
      end
      req_valid = 1'b1; req_int = 3'd2; req_frac = 4'd8;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 17; i++) exp_q.push_back((DITH && (i % 2 == 1)) ? 3 : 2);
      while (n_ps < 17 && t < 80) begin
         if (period_start === 1'b1) begin
            if (n_ps > 0) begin
               total++;
               if (t - last_ps != last_m) begin
                  bad++;
                  $display("FAIL frac_len: t=%0d period=%0d want %0d", t, t - last_ps, last_m);
               end
            end
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL frac_sb: extra period_start at t=%0d want none", t);
            end else begin
               exp_m = exp_q.pop_front();
               if (m_out !== 3'(exp_m)) begin
                  bad++;
                  $display("FAIL frac_m: period=%0d m=%0d want %0d", n_ps, m_out, exp_m);
               end
            end
            last_ps = t; last_m = exp_m; n_ps++;
         end
         if (t == lock_t - 1 || t == lock_t) begin
            total++;
            if (locked !== (t == lock_t)) begin
               bad++;
               $display("FAIL frac_lock: t=%0d locked=%0b want %0b", t, locked, (t == lock_t));
            end
         end
         if (n_ps < 17) begin
            @(negedge clk);
            t++;
         end
      end
      total++;
      if (last_ps != (DITH ? 40 : 32)) begin
         bad++;
         $display("FAIL frac_total: 16 periods took %0d cycles want %0d", last_ps, DITH ? 40 : 32);
      end
      exp_q.delete();
      $display("test_frac: 16 periods of N=2 F=8 in %0d cycles", last_ps);
   endtask

   task automatic test_n7();
      int exp_m;
      int first_len;
      first_len = DITH ? 3 : 2;
      total++;
      if (period_start !== 1'b1 || m_out !== 3'd2) begin
         bad++;
         $display("FAIL n7_align: period_start=%0b m=%0d want 1 2", period_start, m_out);
      end
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL n7_ready: ready=%0b want 1", req_ready);
      end
      // Issued on an update edge: must not commit until the following one.
      req_valid = 1'b1; req_int = 3'd7; req_frac = 4'd15;
      @(negedge clk);
      req_valid = 1'b0;
      exp_q.push_back(first_len);
      for (int i = 0; i < 9; i++) exp_q.push_back(7);
      for (int t = 0; t <= first_len + 56; t++) begin
         total++;
         if (m_out === 3'd0) begin
            bad++;
            $display("FAIL n7_zero: t=%0d m=%0d want nonzero", t, m_out);
         end
         if (period_start === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL n7_sb: extra period_start at t=%0d want none", t);
            end else begin
               exp_m = exp_q.pop_front();
               if (m_out !== 3'(exp_m)) begin
                  bad++;
                  $display("FAIL n7_m: t=%0d m=%0d want %0d", t, m_out, exp_m);
               end
            end
         end
         if (t == first_len + 55 || t == first_len + 56) begin
            total++;
            if (locked !== (t == first_len + 56)) begin
               bad++;
               $display("FAIL n7_lock: t=%0d locked=%0b want %0b", t, locked, (t == first_len + 56));
            end
         end
         if (t < first_len + 56) @(negedge clk);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL n7_sb_left: remaining=%0d want 0", exp_q.size());
         exp_q.delete();
      end
      $display("test_n7: N=7 F=15 held at 7 with no carry");
   endtask

   task automatic test_err();
      total++;
      if (req_ready !== 1'b1 || locked !== 1'b1) begin
         bad++;
         $display("FAIL err_pre: ready=%0b locked=%0b want 1 1", req_ready, locked);
      end
      req_valid = 1'b1; req_int = 3'd0; req_frac = 4'd5;
      @(negedge clk);
      req_valid = 1'b0;
      total++;
      if (req_err !== 1'b1 || req_ready !== 1'b1 || m_out !== 3'd7 || locked !== 1'b1) begin
         bad++;
         $display("FAIL err_pulse: err=%0b ready=%0b m=%0d locked=%0b want 1 1 7 1",
                  req_err, req_ready, m_out, locked);
      end
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         total++;
         if (req_err !== 1'b0 || req_ready !== 1'b1 || m_out !== 3'd7 || locked !== 1'b1) begin
            bad++;
            $display("FAIL err_after: k=%0d err=%0b ready=%0b m=%0d locked=%0b want 0 1 7 1",
                     k, req_err, req_ready, m_out, locked);
         end
      end
      $display("test_err: N=0 request rejected with a single pulse");
   endtask

   task automatic test_reset_pending();
      for (int i = 0; i < 8 && period_start !== 1'b1; i++) @(negedge clk);
      total++;
      if (period_start !== 1'b1) begin
         bad++;
         $display("FAIL rp_align: period_start=%0b want 1", period_start);
      end
      req_valid = 1'b1; req_int = 3'd6; req_frac = 4'd3;
      @(negedge clk);
      req_valid = 1'b0;
      total++;
      if (req_ready !== 1'b0 || m_out !== 3'd7) begin
         bad++;
         $display("FAIL rp_pending: ready=%0b m=%0d want 0 7", req_ready, m_out);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++;
      if (m_out !== 3'd4 || req_ready !== 1'b1 || locked !== 1'b0 || period_start !== 1'b1) begin
         bad++;
         $display("FAIL rp_reset: m=%0d ready=%0b locked=%0b ps=%0b want 4 1 0 1",
                  m_out, req_ready, locked, period_start);
      end
      for (int k = 0; k < 24; k++) begin
         total++;
         if (m_out !== 3'd4 || period_start !== (k % 4 == 0) || locked !== 1'b0) begin
            bad++;
            $display("FAIL rp_after: k=%0d m=%0d ps=%0b locked=%0b want 4 %0b 0",
                     k, m_out, period_start, locked, (k % 4 == 0));
         end
         @(negedge clk);
      end
      $display("test_reset_pending: pending N=6 discarded by reset");
   endtask

   initial begin
      test_reset();
      test_n3();
      test_frac();
      test_n7();
      test_err();
      test_reset_pending();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
